// File: rtl/move_input_conditioner.sv
// rtl/move_input_conditioner.sv - debounce, auto-repeat and single-cycle pulse generation
// for the cursor direction switches and the select/deselect keys.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       select_n_raw,
  input  logic       deselect_n_raw,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       select_pulse,
  output logic       deselect_pulse,
  output logic [3:0] dir_held
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  localparam int NUM_IN  = 6;
  localparam int NUM_DIR = 4;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  // Bit order {up, down, left, right, select_n, deselect_n}; keys idle high.
  localparam logic [NUM_IN-1:0] RELEASED = 6'b000011;

  logic [NUM_IN-1:0]  raw;
  logic [NUM_IN-1:0]  sync1_q, sync1_d;
  logic [NUM_IN-1:0]  sync2_q, sync2_d;
  logic [NUM_IN-1:0]  deb_q, deb_d;
  logic [DB_W-1:0]    db_cnt_q [NUM_IN];
  logic [DB_W-1:0]    db_cnt_d [NUM_IN];

  logic [NUM_DIR-1:0] q_dir;
  logic [NUM_DIR-1:0] q_prev_q, q_prev_d;
  rpt_state_e         st_q [NUM_DIR];
  rpt_state_e         st_d [NUM_DIR];
  logic [RPT_W-1:0]   rpt_cnt_q [NUM_DIR];
  logic [RPT_W-1:0]   rpt_cnt_d [NUM_DIR];
  logic [NUM_DIR-1:0] dir_pulse_q, dir_pulse_d;

  logic [1:0]         key_prev_q, key_prev_d;
  logic [1:0]         key_press;
  logic               sel_pulse_q, sel_pulse_d;
  logic               desel_pulse_q, desel_pulse_d;

  assign raw = {up_raw, down_raw, left_raw, right_raw, select_n_raw, deselect_n_raw};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NUM_IN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    q_dir    = $onehot(deb_q[5:2]) ? deb_q[5:2] : 4'b0000;
    q_prev_d = q_dir;
  end

  always_comb begin
    dir_pulse_d = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      st_d[i]      = st_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (!q_dir[i] || !enable) begin
        st_d[i]      = ST_IDLE;
        rpt_cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            // A qualified level with no fresh 0->1 edge stays parked here.
            if (!q_prev_q[i]) begin
              dir_pulse_d[i] = 1'b1;
              rpt_cnt_d[i]   = '0;
              st_d[i]        = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (rpt_cnt_q[i] == DELAY_LAST) begin
              dir_pulse_d[i] = 1'b1;
              rpt_cnt_d[i]   = '0;
              st_d[i]        = ST_REPEAT;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[i] == PERIOD_LAST) begin
              dir_pulse_d[i] = 1'b1;
              rpt_cnt_d[i]   = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
          end
          default: begin
            st_d[i]      = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    key_prev_d    = deb_q[1:0];
    key_press     = key_prev_q & ~deb_q[1:0];
    sel_pulse_d   = enable & key_press[1] & ~key_press[0];
    desel_pulse_d = enable & key_press[0] & ~key_press[1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q       <= RELEASED;
      sync2_q       <= RELEASED;
      deb_q         <= RELEASED;
      q_prev_q      <= '0;
      key_prev_q    <= 2'b11;
      dir_pulse_q   <= '0;
      sel_pulse_q   <= 1'b0;
      desel_pulse_q <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        db_cnt_q[i] <= '0;
      end
      for (int i = 0; i < NUM_DIR; i++) begin
        st_q[i]      <= ST_IDLE;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      q_prev_q      <= q_prev_d;
      key_prev_q    <= key_prev_d;
      dir_pulse_q   <= dir_pulse_d;
      sel_pulse_q   <= sel_pulse_d;
      desel_pulse_q <= desel_pulse_d;
      for (int i = 0; i < NUM_IN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      for (int i = 0; i < NUM_DIR; i++) begin
        st_q[i]      <= st_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign up_pulse       = dir_pulse_q[3];
  assign down_pulse     = dir_pulse_q[2];
  assign left_pulse     = dir_pulse_q[1];
  assign right_pulse    = dir_pulse_q[0];
  assign select_pulse   = sel_pulse_q;
  assign deselect_pulse = desel_pulse_q;
  assign dir_held       = deb_q[5:2];

endmodule

// File: tb/tb_move_input_conditioner.sv
// tb/tb_move_input_conditioner.sv - directed and randomized checks of move_input_conditioner
// against a cycle-level reference model.
module tb_move_input_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam bit [5:0] REL = 6'b000011;

  logic clk = 1'b0;
  logic resetn, enable;
  logic up_raw, down_raw, left_raw, right_raw, select_n_raw, deselect_n_raw;
  logic up_pulse, down_pulse, left_pulse, right_pulse, select_pulse, deselect_pulse;
  logic [3:0] dir_held;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .up_raw        (up_raw),
    .down_raw      (down_raw),
    .left_raw      (left_raw),
    .right_raw     (right_raw),
    .select_n_raw  (select_n_raw),
    .deselect_n_raw(deselect_n_raw),
    .up_pulse      (up_pulse),
    .down_pulse    (down_pulse),
    .left_pulse    (left_pulse),
    .right_pulse   (right_pulse),
    .select_pulse  (select_pulse),
    .deselect_pulse(deselect_pulse),
    .dir_held      (dir_held)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: raw delay line, window of recent synced samples, per-direction hold age.
  bit [5:0] m_rawq[$];
  bit [5:0] m_win[$];
  bit [5:0] m_deb;
  bit [3:0] m_qprev;
  bit [1:0] m_keyprev;
  bit       m_act[4];
  int       m_age[4];
  bit [3:0] e_dir;
  bit       e_sel, e_desel;

  int n_up, n_down, n_left, n_right, n_sel, n_desel;
  int up_cycles[$];
  int sel_cycles[$];
  int first_up_held;
  bit left_held_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_rawq = {REL, REL};
    m_win.delete();
    for (int k = 0; k < DB; k++) m_win.push_back(REL);
    m_deb     = REL;
    m_qprev   = '0;
    m_keyprev = 2'b11;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 1'b0;
      m_age[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit [5:0] raw_now, synced;
    bit [3:0] q_old;
    bit [1:0] pe;
    bit       all_diff;
    raw_now = {up_raw, down_raw, left_raw, right_raw, select_n_raw, deselect_n_raw};
    q_old   = ($countones(m_deb[5:2]) == 1) ? m_deb[5:2] : 4'b0;
    e_dir   = '0;
    for (int i = 0; i < 4; i++) begin
      if (q_old[i] && enable) begin
        if (!m_act[i]) begin
          if (!m_qprev[i]) begin
            e_dir[i] = 1'b1;
            m_act[i] = 1'b1;
            m_age[i] = 0;
          end
        end else begin
          m_age[i]++;
          if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)) e_dir[i] = 1'b1;
        end
      end else begin
        m_act[i] = 1'b0;
      end
    end
    pe        = m_keyprev & ~m_deb[1:0];
    e_sel     = enable & pe[1] & ~pe[0];
    e_desel   = enable & pe[0] & ~pe[1];
    m_qprev   = q_old;
    m_keyprev = m_deb[1:0];
    synced    = m_rawq.pop_front();
    m_rawq.push_back(raw_now);
    m_win.push_back(synced);
    if (m_win.size() > DB) void'(m_win.pop_front());
    for (int b = 0; b < 6; b++) begin
      all_diff = 1'b1;
      foreach (m_win[k]) if (m_win[k][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) m_deb[b] = ~m_deb[b];
    end
  endtask

  task automatic clear_counts();
    n_up = 0; n_down = 0; n_left = 0; n_right = 0; n_sel = 0; n_desel = 0;
    up_cycles.delete();
    sel_cycles.delete();
    first_up_held  = -1;
    left_held_seen = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("up_pulse",       32'(up_pulse),       32'(e_dir[3]));
    check("down_pulse",     32'(down_pulse),     32'(e_dir[2]));
    check("left_pulse",     32'(left_pulse),     32'(e_dir[1]));
    check("right_pulse",    32'(right_pulse),    32'(e_dir[0]));
    check("select_pulse",   32'(select_pulse),   32'(e_sel));
    check("deselect_pulse", 32'(deselect_pulse), 32'(e_desel));
    check("dir_held",       32'(dir_held),       32'(m_deb[5:2]));
    if (up_pulse) begin n_up++; up_cycles.push_back(cyc); end
    if (down_pulse) n_down++;
    if (left_pulse) n_left++;
    if (right_pulse) n_right++;
    if (select_pulse) begin n_sel++; sel_cycles.push_back(cyc); end
    if (deselect_pulse) n_desel++;
    if (dir_held[3] && first_up_held < 0) first_up_held = cyc;
    if (dir_held[1]) left_held_seen = 1'b1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    check("reset_outputs",
          32'({up_pulse, down_pulse, left_pulse, right_pulse, select_pulse, deselect_pulse, dir_held}),
          32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    cyc = 0;
    clear_counts();
  endtask

  task automatic release_all();
    up_raw = 0; down_raw = 0; left_raw = 0; right_raw = 0;
    select_n_raw = 1; deselect_n_raw = 1;
  endtask

  initial begin
    int rate;
    resetn = 1'b0;
    enable = 1'b1;
    release_all();
    model_reset();
    clear_counts();
    @(posedge clk);
    #1;
    do_reset();

    // Hold up from cycle 0: level at 6, first pulse at 7, repeats at 27/35/43.
    up_raw = 1;
    steps(50);
    check("up_held_cycle", 32'(first_up_held), 32'(6));
    check("up_pulse_count", 32'(n_up), 32'(4));
    if (up_cycles.size() == 4) begin
      check("up_pulse0", 32'(up_cycles[0]), 32'(7));
      check("up_pulse1", 32'(up_cycles[1]), 32'(27));
      check("up_pulse2", 32'(up_cycles[2]), 32'(35));
      check("up_pulse3", 32'(up_cycles[3]), 32'(43));
    end
    up_raw = 0;
    steps(10);

    // Bouncing left never settles.
    clear_counts();
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) left_raw = ~left_raw;
      step();
    end
    left_raw = 0;
    steps(10);
    check("bounce_left_pulses", 32'(n_left), 32'(0));
    check("bounce_left_held", 32'(left_held_seen), 32'(0));

    // Multi-press suppression, then the survivor starts fresh.
    do_reset();
    up_raw = 1;
    steps(10);
    down_raw = 1;
    steps(40);
    check("multi_up_pulses", 32'(n_up), 32'(1));
    check("multi_down_pulses", 32'(n_down), 32'(0));
    clear_counts();
    up_raw = 0;
    steps(20);
    check("survivor_down_pulses", 32'(n_down), 32'(1));
    check("survivor_up_pulses", 32'(n_up), 32'(0));
    down_raw = 0;
    steps(10);

    // Select press: one pulse 7 cycles later, none on release.
    do_reset();
    steps(5);
    select_n_raw = 0;
    begin
      int press_cyc;
      press_cyc = cyc;
      steps(100);
      check("select_count", 32'(n_sel), 32'(1));
      if (sel_cycles.size() > 0) check("select_latency", 32'(sel_cycles[0] - press_cyc), 32'(7));
    end
    clear_counts();
    select_n_raw = 1;
    steps(20);
    check("select_release", 32'(n_sel), 32'(0));

    // Simultaneous select and deselect.
    clear_counts();
    select_n_raw = 0;
    deselect_n_raw = 0;
    steps(30);
    check("both_sel", 32'(n_sel), 32'(0));
    check("both_desel", 32'(n_desel), 32'(0));
    select_n_raw = 1;
    deselect_n_raw = 1;
    steps(10);

    // Held through enable=0 does not fire; a real press does; reset aborts repeat.
    do_reset();
    enable = 0;
    right_raw = 1;
    steps(20);
    enable = 1;
    steps(30);
    check("enable_held_right", 32'(n_right), 32'(0));
    right_raw = 0;
    steps(10);
    clear_counts();
    right_raw = 1;
    steps(40);
    check("repress_right", 32'(n_right), 32'(3));
    do_reset();
    right_raw = 0;
    steps(10);

    // Randomized phases with varying toggle rates, enable changes and occasional reset.
    for (int ph = 0; ph < 30; ph++) begin
      rate = $urandom_range(2, 6);
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(0, (1 << rate) - 1) == 0) up_raw = ~up_raw;
        if ($urandom_range(0, (1 << rate) - 1) == 0) down_raw = ~down_raw;
        if ($urandom_range(0, (1 << rate) - 1) == 0) left_raw = ~left_raw;
        if ($urandom_range(0, (1 << rate) - 1) == 0) right_raw = ~right_raw;
        if ($urandom_range(0, (1 << rate) - 1) == 0) select_n_raw = ~select_n_raw;
        if ($urandom_range(0, (1 << rate) - 1) == 0) deselect_n_raw = ~deselect_n_raw;
        if ($urandom_range(0, 63) == 0) enable = ~enable;
        if ($urandom_range(0, 799) == 0) do_reset();
        step();
      end
      if (ph % 3 == 0) begin
        release_all();
        right_raw = $urandom_range(0, 1);
        enable = 1;
        steps(60);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
